cpu0_mem_arbiter: RTL and testbench

Two-port memory-bus arbiter placed between the cpu0 core and a second bus master (DMA/debug loader) on one side and the single `memory0` port on the other. It grants one transaction at a time, round-robin, and sequences the `m_en`/`m_rw`/`m_size`/address/data strobes with a configurable access length. It decodes the memory-mapped output address: writes there go to a dedicated IO strobe, and out-of-range accesses are rejected with an error.

---
 rtl/cpu0_bus_pkg.sv | 52 +++++
 rtl/cpu0_rr_pick.sv | 26 ++
 rtl/cpu0_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cpu0_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu0_bus_pkg.sv
// Shared definitions for the cpu0 memory bus: size codes, FSM state
// encodings, access classes, default address map and the request record.
package cpu0_bus_pkg;

    // Memory / IO transfer size codes
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_INT16 = 2'b01;
    localparam logic [1:0] SZ_INT24 = 2'b10;
    localparam logic [1:0] SZ_INT32 = 2'b11;

    // Arbiter FSM state encodings
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // What a granted transaction turns into on the bus
    typedef enum logic [1:0] {
        CLS_MEM = 2'd0,
        CLS_IO  = 2'd1,
        CLS_ERR = 2'd2
    } acc_cls_e;

    // Default address map: 512 KiB of memory, output port right above it
    localparam logic [31:0] DEF_MEM_SIZE = 32'h0008_0000;
    localparam logic [31:0] DEF_IO_ADDR  = 32'h0008_0000;

    localparam int NUM_REQ = 2;

    // One captured bus request
    typedef struct packed {
        logic        rw;     // 1 = read, 0 = write
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    // Decode an address/direction pair against the memory map. A memory
    // access must leave room for a full word; the IO port is write-only.
    function automatic acc_cls_e classify(input logic [31:0] addr,
                                          input logic        rw,
                                          input logic [31:0] mem_size,
                                          input logic [31:0] io_addr);
        if (addr <= mem_size - 32'd4)
            return CLS_MEM;
        else if (addr == io_addr && !rw)
            return CLS_IO;
        else
            return CLS_ERR;
    endfunction

endpackage

// File: rtl/cpu0_rr_pick.sv
// Two-way round-robin picker. A lone requester always wins; on contention
// the pointer names the winner and then passes to the loser. The pointer
// is left alone when there is no contention.
module cpu0_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    // One-hot grant and next pointer from the request vector
    always_comb begin
        gnt     = 2'b00;
        ptr_nxt = ptr;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                gnt     = ptr ? 2'b10 : 2'b01;
                ptr_nxt = ~ptr;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// Round-robin arbiter between the cpu0 core (r0) and a second bus master
// (r1) in front of a single memory port. One transaction at a time:
// IDLE picks and captures a request, ACCESS drives the memory or IO
// strobes for WAIT_CYCLES cycles, DONE pulses completion to the owner.
// WAIT_CYCLES must lie in 1..15 (4-bit down-counter).
module cpu0_mem_arbiter
    import cpu0_bus_pkg::*;
#(
    parameter logic [31:0] MEM_SIZE    = DEF_MEM_SIZE,
    parameter logic [31:0] IO_ADDR     = DEF_IO_ADDR,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        r0_req,
    input  logic        r0_rw,
    input  logic [1:0]  r0_size,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic        r0_err,
    output logic [31:0] r0_rdata,

    input  logic        r1_req,
    input  logic        r1_rw,
    input  logic [1:0]  r1_size,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic [31:0] r1_rdata,

    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] m_abus,
    output logic [31:0] m_dout,
    input  logic [31:0] m_din,

    output logic        io_we,
    output logic [1:0]  io_size,
    output logic [31:0] io_data
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES - 1);

    state_t                         state;
    logic                           ptr;
    logic                           ptr_nxt;
    logic                           owner;      // 0 = r0, 1 = r1
    acc_cls_e                       cls;
    bus_req_t                       cur;
    logic [3:0]                     cnt;
    logic                           first;      // first ACCESS cycle
    logic [NUM_REQ-1:0]             req_vec;
    logic [NUM_REQ-1:0]             gnt_vec;
    logic [NUM_REQ-1:0]             done_q;
    logic [NUM_REQ-1:0]             err_q;
    logic [NUM_REQ-1:0][31:0]       rdata_q;
    bus_req_t                       sel;
    logic                           access_end;
    logic                           mem_act;

    assign req_vec    = {r1_req, r0_req};
    assign access_end = (state == ST_ACCESS) && (cnt == 4'd0);

    cpu0_rr_pick u_pick (
        .req     (req_vec),
        .ptr     (ptr),
        .gnt     (gnt_vec),
        .ptr_nxt (ptr_nxt)
    );

    // Mux the winning requester's fields for capture
    always_comb begin
        if (gnt_vec[1])
            sel = '{rw: r1_rw, size: r1_size, addr: r1_addr, wdata: r1_wdata};
        else
            sel = '{rw: r0_rw, size: r0_size, addr: r0_addr, wdata: r0_wdata};
    end

    // Transaction sequencing: IDLE -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            ptr   <= 1'b0;
            cnt   <= 4'd0;
            first <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req_vec) begin
                        ptr   <= ptr_nxt;
                        cnt   <= WAIT_LD;
                        first <= 1'b1;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    first <= 1'b0;
                    if (cnt == 4'd0)
                        state <= ST_DONE;
                    else
                        cnt <= cnt - 4'd1;
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Capture owner, request fields and access class when a grant is made
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner <= 1'b0;
            cur   <= '0;
            cls   <= CLS_MEM;
        end else if (state == ST_IDLE && |req_vec) begin
            owner <= gnt_vec[1];
            cur   <= sel;
            cls   <= classify(sel.addr, sel.rw, MEM_SIZE, IO_ADDR);
        end
    end

    // Completion: one-cycle done/err pulse to the owner, read data held
    // until that requester's next completion. Memory writes leave it as is.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (access_end) begin
                done_q[owner] <= 1'b1;
                err_q[owner]  <= (cls == CLS_ERR);
                if (cls != CLS_MEM)
                    rdata_q[owner] <= 32'd0;
                else if (cur.rw)
                    rdata_q[owner] <= m_din;
            end
        end
    end

    // Requester-side outputs
    assign r0_gnt   = (state != ST_IDLE) && !owner;
    assign r1_gnt   = (state != ST_IDLE) &&  owner;
    assign r0_done  = done_q[0];
    assign r1_done  = done_q[1];
    assign r0_err   = err_q[0];
    assign r1_err   = err_q[1];
    assign r0_rdata = rdata_q[0];
    assign r1_rdata = rdata_q[1];

    // Memory strobes come straight from the captured request, so they
    // hold steady for the whole ACCESS state and are quiet otherwise.
    assign mem_act = (state == ST_ACCESS) && (cls == CLS_MEM);
    assign m_en    = mem_act;
    assign m_rw    = mem_act & cur.rw;
    assign m_size  = mem_act ? cur.size  : 2'b00;
    assign m_abus  = mem_act ? cur.addr  : 32'd0;
    assign m_dout  = mem_act ? cur.wdata : 32'd0;

    // IO write strobe fires once, on the first ACCESS cycle only
    assign io_we   = (state == ST_ACCESS) && (cls == CLS_IO) && first;
    assign io_size = io_we ? cur.size  : 2'b00;
    assign io_data = io_we ? cur.wdata : 32'd0;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Bench for cpu0_mem_arbiter: instance 0 uses WAIT_CYCLES=1, instance 1
// WAIT_CYCLES=3, each with its own byte-wide memory model. Completions are
// checked against a scoreboard of expected (instance, port, rdata, err).
module tb_cpu0_mem_arbiter;
    import cpu0_bus_pkg::*;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] rdata;
        logic        chk;    // compare rdata
        logic        err;
    } exp_t;

    logic        clock, reset;
    logic        r0_req [2], r0_rw [2], r1_req [2], r1_rw [2];
    logic [1:0]  r0_size [2], r1_size [2];
    logic [31:0] r0_addr [2], r0_wdata [2], r1_addr [2], r1_wdata [2];
    logic        r0_gnt [2], r0_done [2], r0_err [2];
    logic        r1_gnt [2], r1_done [2], r1_err [2];
    logic [31:0] r0_rdata [2], r1_rdata [2];
    logic        m_en [2], m_rw [2], io_we [2];
    logic [1:0]  m_size [2], io_size [2];
    logic [31:0] m_abus [2], m_dout [2], io_data [2];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          men_cnt [2];
    int          iowe_cnt [2];
    int          rem0 [2], rem1 [2];
    logic [31:0] io_last [2];
    logic [1:0]  iosz_last [2];
    exp_t        exp_q [$];
    int          done_cyc [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0]  mem [0:4095];
        logic [31:0] din;
        bit          loaded;

        cpu0_mem_arbiter #(.WAIT_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clock(clock), .reset(reset),
            .r0_req(r0_req[g]), .r0_rw(r0_rw[g]), .r0_size(r0_size[g]),
            .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
            .r0_gnt(r0_gnt[g]), .r0_done(r0_done[g]), .r0_err(r0_err[g]),
            .r0_rdata(r0_rdata[g]),
            .r1_req(r1_req[g]), .r1_rw(r1_rw[g]), .r1_size(r1_size[g]),
            .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
            .r1_gnt(r1_gnt[g]), .r1_done(r1_done[g]), .r1_err(r1_err[g]),
            .r1_rdata(r1_rdata[g]),
            .m_en(m_en[g]), .m_rw(m_rw[g]), .m_size(m_size[g]),
            .m_abus(m_abus[g]), .m_dout(m_dout[g]), .m_din(din),
            .io_we(io_we[g]), .io_size(io_size[g]), .io_data(io_data[g])
        );

        // Memory model: little-endian bytes, (size+1) bytes per access
        always @(posedge clock) begin
            if (!loaded) begin
                for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
                mem[256] <= 8'hEF; mem[257] <= 8'hBE;
                mem[258] <= 8'hAD; mem[259] <= 8'hDE;
                loaded <= 1'b1;
            end else if (m_en[g] && !m_rw[g]) begin
                for (int b = 0; b < 4; b++)
                    if (b <= int'(m_size[g]))
                        mem[12'(m_abus[g] + 32'(b))] <= m_dout[g][8*b +: 8];
            end
        end

        always_comb begin
            din = 32'd0;
            for (int b = 0; b < 4; b++)
                if (b <= int'(m_size[g]))
                    din[8*b +: 8] = mem[12'(m_abus[g] + 32'(b))];
        end
    end

    // Advance one cycle, sample #1 after the edge, run the scoreboard and
    // drop a requester's req once its last transaction completes.
    task automatic tick();
        logic d, er;
        logic [31:0] rd;
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (m_en[i] === 1'b1) men_cnt[i]++;
            if (io_we[i] === 1'b1) begin
                iowe_cnt[i]++;
                io_last[i]   = io_data[i];
                iosz_last[i] = io_size[i];
            end
            for (int p = 0; p < 2; p++) begin
                d  = (p == 0) ? r0_done[i]  : r1_done[i];
                er = (p == 0) ? r0_err[i]   : r1_err[i];
                rd = (p == 0) ? r0_rdata[i] : r1_rdata[i];
                if (d === 1'b1) begin
                    done_cyc.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected_done inst=%0d port=%0d got rdata=%h err=%b required no done",
                                 i, p, rd, er);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.inst != i || e.port != p || er !== e.err || (e.chk && rd !== e.rdata)) begin
                            failures++;
                            $display("FAIL sb_done got inst=%0d port=%0d rdata=%h err=%b required inst=%0d port=%0d rdata=%h err=%b",
                                     i, p, rd, er, e.inst, e.port, e.rdata, e.err);
                        end
                    end
                    if (p == 0) begin
                        if (rem0[i] > 0) rem0[i]--;
                        if (rem0[i] == 0) r0_req[i] = 1'b0;
                    end else begin
                        if (rem1[i] > 0) rem1[i]--;
                        if (rem1[i] == 0) r1_req[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drive(input int i, input int p, input logic rw, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            r0_req[i] = 1'b1; r0_rw[i] = rw; r0_size[i] = sz; r0_addr[i] = a; r0_wdata[i] = wd;
            rem0[i] = 1;
        end else begin
            r1_req[i] = 1'b1; r1_rw[i] = rw; r1_size[i] = sz; r1_addr[i] = a; r1_wdata[i] = wd;
            rem1[i] = 1;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({r0_gnt[i], r1_gnt[i], r0_done[i], r1_done[i], r0_err[i], r1_err[i],
                 r0_rdata[i], r1_rdata[i], m_en[i], m_rw[i], m_size[i], m_abus[i],
                 m_dout[i], io_we[i], io_size[i], io_data[i]} !== '0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got m_en=%b gnt=%b%b m_abus=%h required all 0",
                         i, m_en[i], r1_gnt[i], r0_gnt[i], m_abus[i]);
            end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int c;
        c = cyc;
        men_cnt[0] = 0;
        drive(0, 0, 1'b1, SZ_INT32, 32'h100, 32'd0);
        exp_q.push_back('{inst: 0, port: 0, rdata: 32'hDEADBEEF, chk: 1'b1, err: 1'b0});
        tick();
        checks++;
        if ({m_en[0], r0_gnt[0], r1_gnt[0], m_rw[0], m_size[0], m_abus[0]} !==
            {1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 32'h100}) begin
            failures++;
            $display("FAIL read_access got m_en=%b gnt0=%b m_rw=%b m_size=%b m_abus=%h required 1 1 1 11 00000100",
                     m_en[0], r0_gnt[0], m_rw[0], m_size[0], m_abus[0]);
        end
        tick();
        checks++;
        if ({r0_done[0], r0_err[0], m_en[0], r0_rdata[0]} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL read_done at cycle %0d got done=%b err=%b m_en=%b rdata=%h required 1 0 0 deadbeef",
                     cyc - c, r0_done[0], r0_err[0], m_en[0], r0_rdata[0]);
        end
        tick();
        checks++;
        if ({r0_done[0], r0_gnt[0]} !== 2'b00 || men_cnt[0] != 1 || r0_rdata[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_after got done=%b gnt=%b m_en_cycles=%0d rdata=%h required 0 0 1 deadbeef",
                     r0_done[0], r0_gnt[0], men_cnt[0], r0_rdata[0]);
        end
    endtask

    task automatic test_contention();
        int c;
        c = cyc;
        done_cyc.delete();
        drive(0, 0, 1'b1, SZ_INT32, 32'h100, 32'd0);
        drive(0, 1, 1'b1, SZ_INT32, 32'h100, 32'd0);
        rem0[0] = 2;
        rem1[0] = 2;
        for (int k = 0; k < 4; k++)
            exp_q.push_back('{inst: 0, port: k % 2, rdata: 32'hDEADBEEF, chk: 1'b1, err: 1'b0});
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0 || done_cyc.size() != 4) begin
            failures++;
            $display("FAIL contention_count got pending=%0d dones=%0d required 0 4", exp_q.size(), done_cyc.size());
            exp_q.delete();
        end else begin
            checks++;
            if (done_cyc[0] - c != 2) begin
                failures++;
                $display("FAIL contention_first_done got %0d cycles required 2", done_cyc[0] - c);
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (done_cyc[k] - done_cyc[k-1] != 3) begin
                    failures++;
                    $display("FAIL contention_spacing idx=%0d got %0d required 3", k, done_cyc[k] - done_cyc[k-1]);
                end
            end
        end
        tick();
    endtask

    task automatic test_io_write();
        men_cnt[0] = 0;
        iowe_cnt[0] = 0;
        io_last[0] = 32'd0;
        iosz_last[0] = 2'b00;
        drive(0, 0, 1'b0, SZ_INT16, 32'h0008_0000, 32'h0000_6948);
        exp_q.push_back('{inst: 0, port: 0, rdata: 32'd0, chk: 1'b1, err: 1'b0});
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL io_timeout got pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (iowe_cnt[0] != 1 || io_last[0] !== 32'h0000_6948 || iosz_last[0] !== SZ_INT16) begin
            failures++;
            $display("FAIL io_strobe got cycles=%0d data=%h size=%b required 1 00006948 01",
                     iowe_cnt[0], io_last[0], iosz_last[0]);
        end
        checks++;
        if (men_cnt[0] != 0) begin
            failures++;
            $display("FAIL io_m_en got %0d cycles required 0", men_cnt[0]);
        end
    endtask

    task automatic test_error();
        men_cnt[0] = 0;
        drive(0, 1, 1'b1, SZ_INT32, 32'h0008_0000, 32'd0);
        exp_q.push_back('{inst: 0, port: 1, rdata: 32'd0, chk: 1'b1, err: 1'b1});
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        drive(0, 1, 1'b1, SZ_INT32, 32'h0007_FFFD, 32'd0);
        exp_q.push_back('{inst: 0, port: 1, rdata: 32'd0, chk: 1'b1, err: 1'b1});
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL err_timeout got pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (men_cnt[0] != 0 || r1_rdata[0] !== 32'd0) begin
            failures++;
            $display("FAIL err_m_en got m_en_cycles=%0d rdata=%h required 0 00000000", men_cnt[0], r1_rdata[0]);
        end
    endtask

    task automatic test_wait_states();
        int c;
        c = cyc;
        men_cnt[1] = 0;
        done_cyc.delete();
        drive(1, 0, 1'b0, SZ_BYTE, 32'h10, 32'h0000_005A);
        exp_q.push_back('{inst: 1, port: 0, rdata: 32'd0, chk: 1'b0, err: 1'b0});
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0 || done_cyc.size() != 1 || men_cnt[1] != 3) begin
            failures++;
            $display("FAIL wait_write got pending=%0d m_en_cycles=%0d required 0 3", exp_q.size(), men_cnt[1]);
            exp_q.delete();
        end else begin
            checks++;
            if (done_cyc[0] - c != 4) begin
                failures++;
                $display("FAIL wait_latency got %0d cycles required 4", done_cyc[0] - c);
            end
        end
        men_cnt[1] = 0;
        drive(1, 0, 1'b1, SZ_BYTE, 32'h10, 32'd0);
        exp_q.push_back('{inst: 1, port: 0, rdata: 32'h0000_005A, chk: 1'b1, err: 1'b0});
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0 || men_cnt[1] != 3) begin
            failures++;
            $display("FAIL wait_read got pending=%0d m_en_cycles=%0d required 0 3", exp_q.size(), men_cnt[1]);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_midop();
        // r0 wins the tie (pointer moves to r1), then r1's write is cut short
        drive(1, 0, 1'b1, SZ_BYTE, 32'h10, 32'd0);
        drive(1, 1, 1'b0, SZ_INT32, 32'h20, 32'h0000_0077);
        exp_q.push_back('{inst: 1, port: 0, rdata: 32'h0000_005A, chk: 1'b1, err: 1'b0});
        for (int k = 0; k < 20 && r1_gnt[1] !== 1'b1; k++) tick();
        checks++;
        if (r1_gnt[1] !== 1'b1 || m_en[1] !== 1'b1 || m_abus[1] !== 32'h20 || m_rw[1] !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midop_setup got gnt1=%b m_en=%b m_abus=%h pending=%0d required 1 1 00000020 0",
                     r1_gnt[1], m_en[1], m_abus[1], exp_q.size());
            exp_q.delete();
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({r0_gnt[1], r1_gnt[1], r0_done[1], r1_done[1], r0_err[1], r1_err[1],
             r0_rdata[1], r1_rdata[1], m_en[1], m_rw[1], m_size[1], m_abus[1],
             m_dout[1], io_we[1], io_size[1], io_data[1]} !== '0) begin
            failures++;
            $display("FAIL midop_reset_outputs got gnt1=%b m_en=%b m_abus=%h rdata0=%h required all 0",
                     r1_gnt[1], m_en[1], m_abus[1], r0_rdata[1]);
        end
        r0_req[1] = 1'b0; r1_req[1] = 1'b0; rem0[1] = 0; rem1[1] = 0;
        men_cnt[1] = 0;
        tick(); tick(); tick();
        checks++;
        if (men_cnt[1] != 0) begin
            failures++;
            $display("FAIL midop_m_en_in_reset got %0d cycles required 0", men_cnt[1]);
        end
        reset = 1'b1;
        drive(1, 0, 1'b1, SZ_BYTE, 32'h10, 32'd0);
        drive(1, 1, 1'b1, SZ_BYTE, 32'h10, 32'd0);
        exp_q.push_back('{inst: 1, port: 0, rdata: 32'h0000_005A, chk: 1'b1, err: 1'b0});
        exp_q.push_back('{inst: 1, port: 1, rdata: 32'h0000_005A, chk: 1'b1, err: 1'b0});
        tick();
        checks++;
        if ({r0_gnt[1], r1_gnt[1]} !== 2'b10) begin
            failures++;
            $display("FAIL midop_first_grant got gnt0=%b gnt1=%b required 1 0", r0_gnt[1], r1_gnt[1]);
        end
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midop_timeout got pending=%0d required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r0_req[i] = 1'b0; r0_rw[i] = 1'b0; r0_size[i] = 2'b00; r0_addr[i] = 32'd0; r0_wdata[i] = 32'd0;
            r1_req[i] = 1'b0; r1_rw[i] = 1'b0; r1_size[i] = 2'b00; r1_addr[i] = 32'd0; r1_wdata[i] = 32'd0;
            men_cnt[i] = 0; iowe_cnt[i] = 0; rem0[i] = 0; rem1[i] = 0;
            io_last[i] = 32'd0; iosz_last[i] = 2'b00;
        end
        test_reset();
        test_single_read();
        test_contention();
        test_io_write();
        test_error();
        test_wait_states();
        test_reset_midop();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
